fp_normalizer: RTL and testbench
================================

FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 Parameter EXP_W, default 6, exponent width.
REQ-002 Parameter MAN_W, default 12, mantissa width; normalized means bit MAN_W-1 set.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 InValid  input  1  raw adder result present on the In* ports.
REQ-006 InReady  output  1  block accepts a result this cycle.
REQ-007 SignIn  input  1  raw sign.
REQ-008 ExponentIn  input  EXP_W  raw exponent.
REQ-009 MantissaIn  input  MAN_W  raw mantissa.
REQ-010 CoutIn  input  1  mantissa carry-out from the adder.
REQ-011 OutValid  output  1  normalized result valid.
REQ-012 OutReady  input  1  downstream accepts the result.
REQ-013 SignOut, ExponentOut, MantissaOut  output  1/EXP_W/MAN_W  normalized result.
REQ-014 Overflow, Underflow  output  1 each  qualify the current result; valid only with OutValid.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 InReady SHALL be 1 only in IDLE; the block SHALL accept input when InValid and InReady are both 1.
REQ-017 On accept with CoutIn=1 and ExponentIn<max: mantissa := {1,MantissaIn[MAN_W-1:1]}; exponent +1; next state DONE.
REQ-018 On accept with CoutIn=1 and ExponentIn=max: exponent := max; mantissa := all ones; Overflow := 1; next state DONE.
REQ-019 On accept with CoutIn=0 and MantissaIn=0: sign, exponent and mantissa := 0 (canonical zero); next state DONE.
REQ-020 On accept with CoutIn=0 and MantissaIn MSB set: the input SHALL pass through unchanged; next state DONE.
REQ-021 Otherwise the block SHALL capture the input and enter SHIFT.
REQ-022 SHIFT behaviour, per cycle:
  - if exponent=1: result := canonical zero; Underflow := 1; next state DONE.
  - else: mantissa shifts left by 1; exponent -1.
  - the block SHALL go to DONE in the cycle the shifted mantissa MSB becomes 1.
REQ-023 Exponent 0 SHALL be reserved for zero; a nonzero result SHALL never carry exponent 0.
REQ-024 Latency from the accept edge to OutValid SHALL be 1 cycle plus one cycle per left shift (maximum MAN_W).
REQ-025 In DONE, OutValid SHALL be 1 and all outputs SHALL hold stable until OutReady=1; that edge SHALL return the FSM to IDLE.
REQ-026 A new input SHALL NOT be accepted in the cycle the output handshake completes; throughput is at most one result per 2 cycles.
REQ-027 SignOut SHALL equal the captured sign, except on the canonical-zero path (REQ-019, REQ-022), where it SHALL be 0.

Reset
REQ-028 Reset SHALL force IDLE and drive OutValid, SignOut, ExponentOut, MantissaOut, Overflow and Underflow to 0.
REQ-029 Reset SHALL take priority over all handshakes and SHALL abort an in-flight SHIFT or DONE with no output produced.

Structure
REQ-030 A shared package SHALL hold EXP_W, MAN_W, EXP_MAX (2^EXP_W-1) and the state encoding.
REQ-031 The block SHALL be a single module with no sub-module; the shifter is iterative and needs no leading-one detector.

Verification
REQ-032 Input S0 E=10 M=0x800 C=0 -> OutValid 1 cycle after accept; E=10, M=0x800, no flags.
REQ-033 Input E=10 M=0x400 C=1 -> M=0xA00, E=11 after 1 cycle; input E=63 C=1 -> E=63, M=0xFFF, Overflow=1.
REQ-034 Input S1 E=20 M=0x010 C=0 -> 7 shifts; OutValid 8 cycles after accept; S1, E=13, M=0x800.
REQ-035 Input E=3 M=0x001 -> after 3 SHIFT cycles S0, E=0, M=0, Underflow=1; input M=0 -> zero output after 1 cycle.
REQ-036 Hold OutReady=0 for 5 cycles in DONE -> outputs stable and InReady=0 throughout; release -> IDLE on the next edge.
REQ-037 Assert Reset during the 3rd SHIFT cycle -> next cycle IDLE, OutValid=0, all outputs 0, InReady=1.

Source files
------------

// File: rtl/fp_normalizer_pkg.sv
// fp_normalizer_pkg: shared widths, exponent ceiling and FSM state encoding
package fp_normalizer_pkg;
  localparam int EXP_W = 6;
  localparam int MAN_W = 12;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;
endpackage

// File: rtl/fp_normalizer_if.sv
// fp_normalizer_if: raw-result input and normalized-result output handshakes
interface fp_normalizer_if #(
  parameter int EXP_W = fp_normalizer_pkg::EXP_W,
  parameter int MAN_W = fp_normalizer_pkg::MAN_W
);
  logic InValid;
  logic InReady;
  logic SignIn;
  logic [EXP_W-1:0] ExponentIn;
  logic [MAN_W-1:0] MantissaIn;
  logic CoutIn;
  logic OutValid;
  logic OutReady;
  logic SignOut;
  logic [EXP_W-1:0] ExponentOut;
  logic [MAN_W-1:0] MantissaOut;
  logic Overflow;
  logic Underflow;
  modport master (
    output InValid, SignIn, ExponentIn, MantissaIn, CoutIn, OutReady,
    input InReady, OutValid, SignOut, ExponentOut, MantissaOut, Overflow, Underflow
  );
  modport slave (
    input InValid, SignIn, ExponentIn, MantissaIn, CoutIn, OutReady,
    output InReady, OutValid, SignOut, ExponentOut, MantissaOut, Overflow, Underflow
  );
endinterface

// File: rtl/fp_normalizer.sv
// fp_normalizer: iterative post-add normalizer, one left shift per cycle
module fp_normalizer #(
  parameter int EXP_W = fp_normalizer_pkg::EXP_W,
  parameter int MAN_W = fp_normalizer_pkg::MAN_W
) (
  input logic Clock,
  input logic Reset,
  fp_normalizer_if.slave bus
);
  import fp_normalizer_pkg::*;
  localparam logic [EXP_W-1:0] ExpTop = '1;
  stateT state, stateNext;
  logic sign, signNext;
  logic [EXP_W-1:0] exponent, exponentNext;
  logic [MAN_W-1:0] mantissa, mantissaNext, shifted;
  logic overflow, overflowNext, underflow, underflowNext;
  assign shifted = {mantissa[MAN_W-2:0], 1'b0};
  // Next state and next result: classify on accept, then shift until the MSB lands or the exponent runs out
  always_comb begin
    stateNext = state;
    signNext = sign;
    exponentNext = exponent;
    mantissaNext = mantissa;
    overflowNext = overflow;
    underflowNext = underflow;
    case (state)
      IDLE: if (bus.InValid) begin
        stateNext = DONE;
        signNext = bus.SignIn;
        exponentNext = bus.ExponentIn;
        mantissaNext = bus.MantissaIn;
        overflowNext = 1'b0;
        underflowNext = 1'b0;
        if (bus.CoutIn) begin
          if (bus.ExponentIn == ExpTop) begin
            mantissaNext = '1;
            overflowNext = 1'b1;
          end else begin
            exponentNext = bus.ExponentIn + 1'b1;
            mantissaNext = {1'b1, bus.MantissaIn[MAN_W-1:1]};
          end
        end else if (bus.MantissaIn == '0) begin
          signNext = 1'b0;
          exponentNext = '0;
        end else if (!bus.MantissaIn[MAN_W-1]) begin
          stateNext = SHIFT;
        end
      end
      SHIFT: if (exponent <= EXP_W'(1)) begin
        stateNext = DONE;
        signNext = 1'b0;
        exponentNext = '0;
        mantissaNext = '0;
        underflowNext = 1'b1;
      end else begin
        exponentNext = exponent - 1'b1;
        mantissaNext = shifted;
        stateNext = shifted[MAN_W-1] ? DONE : SHIFT;
      end
      DONE: stateNext = bus.OutReady ? IDLE : DONE;
      default: stateNext = IDLE;
    endcase
  end
  // State and result registers; reset clears everything and aborts any work in flight
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      sign <= 1'b0;
      exponent <= '0;
      mantissa <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= stateNext;
      sign <= signNext;
      exponent <= exponentNext;
      mantissa <= mantissaNext;
      overflow <= overflowNext;
      underflow <= underflowNext;
    end
  end
  assign bus.InReady = state == IDLE;
  assign bus.OutValid = state == DONE;
  assign bus.SignOut = sign;
  assign bus.ExponentOut = exponent;
  assign bus.MantissaOut = mantissa;
  assign bus.Overflow = overflow;
  assign bus.Underflow = underflow;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed self-checking bench for fp_normalizer
module tb_fp_normalizer;
  import fp_normalizer_pkg::*;
  logic Clock = 1'b0;
  logic Reset;
  int compared = 0;
  int mismatched = 0;
  int lat;
  fp_normalizer_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
  fp_normalizer #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chkOut(input string tag, input logic s, input int e, input int m, input logic o, input logic u);
    chk({tag, ".valid"}, 32'(bus.OutValid), 1);
    chk({tag, ".sign"}, 32'(bus.SignOut), 32'(s));
    chk({tag, ".exp"}, 32'(bus.ExponentOut), e);
    chk({tag, ".man"}, 32'(bus.MantissaOut), m);
    chk({tag, ".ovf"}, 32'(bus.Overflow), 32'(o));
    chk({tag, ".unf"}, 32'(bus.Underflow), 32'(u));
  endtask
  task automatic send(input logic s, input int e, input int m, input logic c);
    bus.InValid = 1'b1;
    bus.SignIn = s;
    bus.ExponentIn = EXP_W'(e);
    bus.MantissaIn = MAN_W'(m);
    bus.CoutIn = c;
    tick();
    bus.InValid = 1'b0;
  endtask
  task automatic waitOut(output int n);
    n = 1;
    while (!bus.OutValid && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic finishOut(input string tag);
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
    chk({tag, ".idleValid"}, 32'(bus.OutValid), 0);
    chk({tag, ".idleReady"}, 32'(bus.InReady), 1);
  endtask
  initial begin
    Reset = 1'b1;
    bus.InValid = 1'b0;
    bus.SignIn = 1'b0;
    bus.ExponentIn = '0;
    bus.MantissaIn = '0;
    bus.CoutIn = 1'b0;
    bus.OutReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst.ready", 32'(bus.InReady), 1);
    chk("rst.valid", 32'(bus.OutValid), 0);
    chk("rst.sign", 32'(bus.SignOut), 0);
    chk("rst.exp", 32'(bus.ExponentOut), 0);
    chk("rst.man", 32'(bus.MantissaOut), 0);
    chk("rst.flags", 32'({bus.Overflow, bus.Underflow}), 0);
    send(1'b0, 10, 'h800, 1'b0);
    waitOut(lat);
    chk("pass.lat", lat, 1);
    chkOut("pass", 1'b0, 10, 'h800, 1'b0, 1'b0);
    finishOut("pass");
    send(1'b0, 10, 'h400, 1'b1);
    waitOut(lat);
    chk("carry.lat", lat, 1);
    chkOut("carry", 1'b0, 11, 'hA00, 1'b0, 1'b0);
    finishOut("carry");
    send(1'b1, EXP_MAX, 'h123, 1'b1);
    waitOut(lat);
    chk("ovf.lat", lat, 1);
    chkOut("ovf", 1'b1, EXP_MAX, 'hFFF, 1'b1, 1'b0);
    finishOut("ovf");
    send(1'b1, 20, 'h010, 1'b0);
    chk("shift.busyReady", 32'(bus.InReady), 0);
    waitOut(lat);
    chk("shift.lat", lat, 8);
    chkOut("shift", 1'b1, 13, 'h800, 1'b0, 1'b0);
    finishOut("shift");
    send(1'b1, 3, 'h001, 1'b0);
    waitOut(lat);
    chk("unf.lat", lat, 4);
    chkOut("unf", 1'b0, 0, 0, 1'b0, 1'b1);
    finishOut("unf");
    send(1'b1, 5, 0, 1'b0);
    waitOut(lat);
    chk("zero.lat", lat, 1);
    chkOut("zero", 1'b0, 0, 0, 1'b0, 1'b0);
    finishOut("zero");
    send(1'b0, 7, 'h900, 1'b0);
    bus.InValid = 1'b1;
    bus.SignIn = 1'b1;
    bus.ExponentIn = EXP_W'(9);
    bus.MantissaIn = MAN_W'('h801);
    bus.CoutIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chkOut("hold", 1'b0, 7, 'h900, 1'b0, 1'b0);
      chk("hold.ready", 32'(bus.InReady), 0);
      tick();
    end
    finishOut("hold");
    tick();
    bus.InValid = 1'b0;
    chkOut("next", 1'b1, 9, 'h801, 1'b0, 1'b0);
    finishOut("next");
    send(1'b1, 20, 'h010, 1'b0);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort.ready", 32'(bus.InReady), 1);
    chk("abort.valid", 32'(bus.OutValid), 0);
    chk("abort.outs", 32'({bus.SignOut, bus.ExponentOut, bus.MantissaOut, bus.Overflow, bus.Underflow}), 0);
    tick();
    tick();
    chk("abort.stillIdle", 32'({bus.OutValid, bus.InReady}), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
